hazard_scoreboard: RTL

//   Parametrised ID-stage hazard unit for the in-order RISC-V pipeline. Generalises load-use

---
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard for long-latency
// writebacks (loads, MUL/DIV) and an MDU occupancy counter. Stalls ID on
// RAW/WAW against pending results and on MDU structural conflicts.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   rs1_id,
    input  logic [REG_AW-1:0]   rs2_id,
    input  logic                rs1_used_id,
    input  logic                rs2_used_id,
    input  logic [REG_AW-1:0]   rd_id,
    input  logic                reg_write_id,
    input  logic                mdu_id,
    input  logic                ex_valid,
    input  logic [REG_AW-1:0]   rd_ex,
    input  logic                reg_write_ex,
    input  logic                mem_read_ex,
    input  logic                mdu_ex,
    input  logic                flush,
    output logic                pc_w,
    output logic                pipeline_id_en,
    output logic                hazard_mux_sel,
    output logic                mdu_busy,
    output logic [STALL_CW-1:0] stall_count
);

    localparam int MAX_LAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int MCNT_W  = $clog2(MDU_LAT + 1);

    localparam logic [CNT_W-1:0]  LOAD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]  MDU_INIT  = CNT_W'(MDU_LAT - 1);
    localparam logic [MCNT_W-1:0] MBUSY_INIT = MCNT_W'(MDU_LAT - 1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [MCNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [STALL_CW-1:0] stall_count_q, stall_count_d;

    logic [NUM_REGS-1:0] cnt_nz;
    logic                ex_long;
    logic                rs1_pend, rs2_pend, rd_pend;
    logic                raw, waw, strc, stall;

    // Long-latency producer currently in EX, and which registers are still counting.
    always_comb begin
        ex_long = ex_valid & reg_write_ex & (rd_ex != '0) & (mem_read_ex | mdu_ex);
        cnt_nz  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_nz[r] = (cnt_q[r] != '0);
        end
    end

    // Hazard detection; outputs held in no-stall form while reset is asserted.
    always_comb begin
        rs1_pend = (rs1_id != '0) & (cnt_nz[rs1_id] | (ex_long & (rd_ex == rs1_id)));
        rs2_pend = (rs2_id != '0) & (cnt_nz[rs2_id] | (ex_long & (rd_ex == rs2_id)));
        rd_pend  = (rd_id  != '0) & (cnt_nz[rd_id]  | (ex_long & (rd_ex == rd_id)));
        raw      = (rs1_used_id & rs1_pend) | (rs2_used_id & rs2_pend);
        waw      = reg_write_id & rd_pend;
        strc     = mdu_id & (mdu_busy | (ex_valid & mdu_ex));
        stall    = arst_n & id_valid & ~flush & (raw | waw | strc);

        pc_w           = ~stall;
        pipeline_id_en = ~stall;
        hazard_mux_sel = stall;
        mdu_busy       = arst_n & (mdu_cnt_q != '0);
        stall_count    = stall_count_q;
    end

    // Next-state for scoreboard counters, MDU occupancy and stall counter.
    // A set from EX takes priority over the decrement of the same register;
    // when a load is also flagged as MDU the MDU latency is used.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = '0;
            if (r != 0) begin
                if (ex_long && (rd_ex == REG_AW'(r))) begin
                    cnt_d[r] = mdu_ex ? MDU_INIT : LOAD_INIT;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end else begin
                    cnt_d[r] = '0;
                end
            end
        end

        mdu_cnt_d = mdu_cnt_q;
        if (ex_valid && mdu_ex) begin
            mdu_cnt_d = MBUSY_INIT;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - 1'b1;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State registers; reset discards all pending writebacks.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            mdu_cnt_q     <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            mdu_cnt_q     <= mdu_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
